// File: rtl/rtc_cnt_ctrl.sv
// RTC time-base sequencer: divides TickIn down to seconds, keeps the 32-bit
// seconds counter with load/match, and produces the raw/masked match interrupt.
module rtc_cnt_ctrl #(
    parameter int unsigned PRESCALE = 32768,
    parameter int unsigned PRE_W    = 15
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        TickIn,
    input  logic        Enable,
    input  logic        LoadValid,
    input  logic [31:0] LoadData,
    input  logic        MatchWr,
    input  logic [31:0] MatchData,
    input  logic        IntMask,
    input  logic        IntClr,
    input  logic        Revision,
    output logic [31:0] Count,
    output logic [31:0] MatchReg,
    output logic        SecPulse,
    output logic        RawInt,
    output logic        RTCINTR,
    output logic        RevId,
    output logic        Running
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic             tick_run;
    logic             inc;
    logic             eq;
    logic             eq_q;

    // NOTE: every branch starts from the held state, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:    if (Enable)  state_d = RUN;
            RUN:     if (!Enable) state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    assign tick_run = (state_q == RUN) && TickIn;
    assign inc      = tick_run && (pre_q == PRE_LAST);
    assign eq       = (Count == MatchReg);
    assign Running  = (state_q == RUN);
    assign RTCINTR  = RawInt & IntMask;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= STOP;
            pre_q    <= '0;
            Count    <= '0;
            MatchReg <= '0;
            SecPulse <= 1'b0;
            RawInt   <= 1'b0;
            eq_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            SecPulse <= inc && !LoadValid;
            eq_q     <= eq;

            // A load restarts the second and swallows a coincident increment.
            if (LoadValid) begin
                Count <= LoadData;
                pre_q <= '0;
            end else begin
                if (tick_run) pre_q <= inc ? '0 : pre_q + PRE_W'(1);
                if (inc)      Count <= Count + 32'd1;
            end

            if (MatchWr) MatchReg <= MatchData;

            // Rising equality outranks a same-cycle clear.
            if (eq && !eq_q)  RawInt <= 1'b1;
            else if (IntClr)  RawInt <= 1'b0;
        end
    end

    // The revision bit is sampled on every edge, reset included.
    always_ff @(posedge PCLK) begin
        RevId <= Revision;
    end

endmodule

// File: tb/tb_rtc_cnt_ctrl.sv
// Bench for rtc_cnt_ctrl: directed vector table, corner-case sequences and
// random stimulus, all compared against a cycle-level behavioural model.
module tb_rtc_cnt_ctrl;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PRE_W    = 2;

    logic        PCLK = 1'b0;
    logic        PRESET, TickIn, Enable, LoadValid, MatchWr, IntMask, IntClr, Revision;
    logic [31:0] LoadData, MatchData;
    logic [31:0] Count, MatchReg;
    logic        SecPulse, RawInt, RTCINTR, RevId, Running;

    rtc_cnt_ctrl #(.PRESCALE(PRESCALE), .PRE_W(PRE_W)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .TickIn(TickIn), .Enable(Enable),
        .LoadValid(LoadValid), .LoadData(LoadData), .MatchWr(MatchWr),
        .MatchData(MatchData), .IntMask(IntMask), .IntClr(IntClr),
        .Revision(Revision), .Count(Count), .MatchReg(MatchReg),
        .SecPulse(SecPulse), .RawInt(RawInt), .RTCINTR(RTCINTR),
        .RevId(RevId), .Running(Running)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          rst, en, tick, load;
        logic [31:0] ldata;
        bit          mwr;
        logic [31:0] mdata;
        bit          mask, clr, rev;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] e_count;
        bit          e_sec, e_raw, e_int, e_run;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: values the outputs should hold after each edge.
    logic [31:0] m_count, m_match;
    int          m_ticks;
    bit          m_run, m_sec, m_raw, m_eq_prev, m_rev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit rst, bit en, bit tick, bit load, logic [31:0] ldata,
                                 bit mwr, logic [31:0] mdata, bit mask, bit clr, bit rev);
        stim_t s;
        s.rst = rst; s.en = en; s.tick = tick; s.load = load; s.ldata = ldata;
        s.mwr = mwr; s.mdata = mdata; s.mask = mask; s.clr = clr; s.rev = rev;
        return s;
    endfunction

    function automatic vec_t v(bit rst, bit en, bit tick, bit load, logic [31:0] ldata,
                               bit mwr, logic [31:0] mdata, bit mask, bit clr,
                               logic [31:0] ec, bit es, bit er, bit ei, bit eru);
        vec_t r;
        r.s = mk(rst, en, tick, load, ldata, mwr, mdata, mask, clr, rst);
        r.e_count = ec; r.e_sec = es; r.e_raw = er; r.e_int = ei; r.e_run = eru;
        return r;
    endfunction

    // One clock edge of the specified behaviour, written from the rules directly.
    task automatic model_edge(input stim_t s);
        bit second_done, same;
        if (s.rst) begin
            m_count = 0; m_match = 0; m_ticks = 0; m_run = 0;
            m_sec = 0; m_raw = 0; m_eq_prev = 1;
        end else begin
            second_done = m_run && s.tick && (m_ticks == PRESCALE - 1);
            same        = (m_count == m_match);
            if (same && !m_eq_prev) m_raw = 1;
            else if (s.clr)         m_raw = 0;
            m_eq_prev = same;
            m_sec     = second_done && !s.load;
            if (s.load) begin
                m_count = s.ldata;
                m_ticks = 0;
            end else begin
                if (m_run && s.tick) m_ticks = (m_ticks + 1) % PRESCALE;
                if (second_done)     m_count = m_count + 32'd1;
            end
            if (s.mwr) m_match = s.mdata;
            m_run = s.en;
        end
        m_rev = s.rev;
    endtask

    task automatic cycle(input stim_t s);
        PRESET = s.rst; Enable = s.en; TickIn = s.tick; LoadValid = s.load;
        LoadData = s.ldata; MatchWr = s.mwr; MatchData = s.mdata;
        IntMask = s.mask; IntClr = s.clr; Revision = s.rev;
        @(posedge PCLK);
        model_edge(s);
        #1;
        check("count",   Count,          m_count);
        check("match",   MatchReg,       m_match);
        check("sec",     32'(SecPulse),  32'(m_sec));
        check("raw",     32'(RawInt),    32'(m_raw));
        check("rtcintr", 32'(RTCINTR),   32'(m_raw & s.mask));
        check("running", 32'(Running),   32'(m_run));
        check("revid",   32'(RevId),     32'(m_rev));
    endtask

    vec_t  tbl [21];
    stim_t s;
    bit    en_lvl;

    initial begin
        tbl[0]  = v(1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
        tbl[1]  = v(0,1,1,0,0,0,0,0,0, 0,0,0,0,1);
        tbl[2]  = v(0,1,1,0,0,0,0,0,0, 0,0,0,0,1);
        tbl[3]  = v(0,1,1,0,0,0,0,0,0, 0,0,0,0,1);
        tbl[4]  = v(0,1,1,0,0,0,0,0,0, 0,0,0,0,1);
        tbl[5]  = v(0,1,1,0,0,0,0,0,0, 1,1,0,0,1);
        tbl[6]  = v(0,1,1,0,0,0,0,0,0, 1,0,0,0,1);
        tbl[7]  = v(0,1,1,1,3,1,5,1,0, 3,0,0,0,1);
        tbl[8]  = v(0,1,1,0,0,0,0,1,0, 3,0,0,0,1);
        tbl[9]  = v(0,1,1,0,0,0,0,1,0, 3,0,0,0,1);
        tbl[10] = v(0,1,1,0,0,0,0,1,0, 3,0,0,0,1);
        tbl[11] = v(0,1,1,0,0,0,0,1,0, 4,1,0,0,1);
        tbl[12] = v(0,1,1,0,0,0,0,1,0, 4,0,0,0,1);
        tbl[13] = v(0,1,1,0,0,0,0,1,0, 4,0,0,0,1);
        tbl[14] = v(0,1,1,0,0,0,0,1,0, 4,0,0,0,1);
        tbl[15] = v(0,1,1,0,0,0,0,1,0, 5,1,0,0,1);
        tbl[16] = v(0,1,1,0,0,0,0,1,0, 5,0,1,1,1);
        tbl[17] = v(0,1,1,0,0,0,0,0,0, 5,0,1,0,1);
        tbl[18] = v(0,1,1,0,0,0,0,1,0, 5,0,1,1,1);
        tbl[19] = v(0,1,1,0,0,0,0,1,0, 6,1,1,1,1);
        tbl[20] = v(0,1,1,0,0,0,0,1,1, 6,0,0,0,1);

        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].s);
            check($sformatf("tbl%0d_count", i), Count,         tbl[i].e_count);
            check($sformatf("tbl%0d_sec", i),   32'(SecPulse), 32'(tbl[i].e_sec));
            check($sformatf("tbl%0d_raw", i),   32'(RawInt),   32'(tbl[i].e_raw));
            check($sformatf("tbl%0d_int", i),   32'(RTCINTR),  32'(tbl[i].e_int));
            check($sformatf("tbl%0d_run", i),   32'(Running),  32'(tbl[i].e_run));
        end

        // Load near the top while running; prescaler restarts from the load.
        cycle(mk(0,1,1,1,32'hFFFF_FFFE,0,0,1,0,0));
        check("wrap_load", Count, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) cycle(mk(0,1,1,0,0,0,0,1,0,0));
        check("wrap_hold", Count, 32'hFFFF_FFFE);
        cycle(mk(0,1,1,0,0,0,0,1,0,0));
        check("wrap_ff", Count, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) cycle(mk(0,1,1,0,0,0,0,1,0,0));
        check("wrap_zero", Count, 32'h0);
        check("wrap_sec", 32'(SecPulse), 32'd1);

        // Clear coinciding with a fresh rising equality loses to the set.
        cycle(mk(0,0,0,1,32'h10,1,32'h10,1,0,0));
        check("eqld_raw0", 32'(RawInt), 32'd0);
        cycle(mk(0,0,0,0,0,0,0,1,1,0));
        check("setclr_raw", 32'(RawInt), 32'd1);
        check("setclr_int", 32'(RTCINTR), 32'd1);
        cycle(mk(0,0,0,0,0,0,0,1,0,0));
        check("persist_raw", 32'(RawInt), 32'd1);
        cycle(mk(0,0,0,0,0,0,0,1,1,0));
        check("clr_raw", 32'(RawInt), 32'd0);
        cycle(mk(0,0,0,0,0,0,0,1,0,0));
        check("noretrig_raw", 32'(RawInt), 32'd0);

        // Stop with the prescaler at 2; ticks while stopped must not count.
        cycle(mk(0,1,0,1,32'd100,0,0,1,0,0));
        cycle(mk(0,1,1,0,0,0,0,1,0,0));
        cycle(mk(0,1,1,0,0,0,0,1,0,0));
        cycle(mk(0,0,0,0,0,0,0,1,0,0));
        check("stop_running", 32'(Running), 32'd0);
        for (int i = 0; i < 10; i++) cycle(mk(0,0,1,0,0,0,0,1,0,0));
        check("stop_count", Count, 32'd100);
        cycle(mk(0,1,0,0,0,0,0,1,0,0));
        check("restart_running", 32'(Running), 32'd1);
        cycle(mk(0,1,1,0,0,0,0,1,0,0));
        check("resume_hold", Count, 32'd100);
        cycle(mk(0,1,1,0,0,0,0,1,0,0));
        check("resume_inc", Count, 32'd101);
        check("resume_sec", 32'(SecPulse), 32'd1);

        // Reset mid-run with strobes pending; 0==0 afterwards must stay quiet.
        for (int i = 0; i < 3; i++) cycle(mk(0,1,1,0,0,0,0,1,0,0));
        cycle(mk(1,1,1,1,32'h20,1,32'h33,1,1,1));
        check("rst_count", Count, 32'd0);
        check("rst_match", MatchReg, 32'd0);
        check("rst_raw", 32'(RawInt), 32'd0);
        check("rst_int", 32'(RTCINTR), 32'd0);
        check("rst_running", 32'(Running), 32'd0);
        check("rst_revid", 32'(RevId), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0,0,0,0,0,0,0,1,0,1));
            check("post_rst_raw", 32'(RawInt), 32'd0);
        end

        // Random traffic, steering loads and match writes toward equality.
        en_lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) en_lvl = !en_lvl;
            s.rst   = ($urandom_range(0, 299) == 0);
            s.en    = en_lvl;
            s.tick  = 1'($urandom_range(0, 1));
            s.load  = ($urandom_range(0, 39) == 0);
            s.ldata = ($urandom_range(0, 1) == 1) ? m_match - 32'($urandom_range(0, 3)) : $urandom();
            s.mwr   = ($urandom_range(0, 49) == 0);
            s.mdata = m_count + 32'($urandom_range(0, 4));
            s.mask  = 1'($urandom_range(0, 1));
            s.clr   = ($urandom_range(0, 7) == 0);
            s.rev   = 1'($urandom_range(0, 1));
            cycle(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
